// File: rtl/mutex_acquire_agent.sv
// Purpose : Avalon-MM client that acquires and releases a hardware mutex for one requester.
// Latency : acquire 3 cycles uncontended (+2+BACKOFF_CYCLES per failed check); release write 1 cycle, rel_done 1 cycle later.
// Backpres: slave has zero wait states; requests are level-sampled, acq_req in IDLE only, rel_req in HELD only.
//
// Ports:
//   clk, reset_n                 - clock, synchronous active-low reset
//   acq_req / rel_req            - acquire / release requests
//   granted, acq_fail, rel_done  - lock held, retries exhausted pulse, release issued pulse
//   busy, retry_count            - transaction in flight, failed checks in current acquire
//   mutex_*                      - Avalon-MM master towards the mutex slave
module mutex_acquire_agent #(
    parameter logic [15:0] OWNER_ID       = 16'h0001,
    parameter logic [15:0] LOCK_VALUE     = 16'h0001,
    parameter int          BACKOFF_CYCLES = 8,
    parameter int          MAX_RETRIES    = 0,
    parameter int          RETRY_W        = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               acq_req,
    input  logic               rel_req,
    output logic               granted,
    output logic               acq_fail,
    output logic               rel_done,
    output logic               busy,
    output logic [RETRY_W-1:0] retry_count,
    output logic               mutex_address,
    output logic               mutex_chipselect,
    output logic               mutex_read,
    output logic               mutex_write,
    output logic [31:0]        mutex_writedata,
    input  logic [31:0]        mutex_readdata
);

    localparam int                 BO_W      = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
    localparam logic [BO_W-1:0]    BO_LOAD   = BO_W'(BACKOFF_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRIES);
    localparam logic [31:0]        ACQ_WORD  = {OWNER_ID, LOCK_VALUE};
    localparam logic [31:0]        REL_WORD  = {OWNER_ID, 16'h0000};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQ_WR  = 3'd1,
        ACQ_RD  = 3'd2,
        BACKOFF = 3'd3,
        HELD    = 3'd4,
        REL_WR  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic [BO_W-1:0]    bo_q, bo_d;
    logic               acq_fail_q, acq_fail_d;
    logic               rel_done_q, rel_done_d;

    // Saturating increment so a retry-forever agent never wraps back to 0.
    assign retry_inc = (&retry_q) ? retry_q : retry_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            retry_q    <= '0;
            bo_q       <= '0;
            acq_fail_q <= 1'b0;
            rel_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            bo_q       <= bo_d;
            acq_fail_q <= acq_fail_d;
            rel_done_q <= rel_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        bo_d       = bo_q;
        acq_fail_d = 1'b0;
        rel_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                // rel_req is deliberately not looked at here: acquire wins.
                if (acq_req) begin
                    state_d = ACQ_WR;
                    retry_d = '0;
                end
            end
            ACQ_WR: state_d = ACQ_RD;
            ACQ_RD: begin
                // The slave only keeps our write if the lock was free or already ours,
                // so reading our own word back is the ownership proof.
                if (mutex_readdata == ACQ_WORD) begin
                    state_d = HELD;
                end else begin
                    retry_d = retry_inc;
                    if ((MAX_RETRIES != 0) && (retry_inc >= RETRY_LIM)) begin
                        state_d    = IDLE;
                        acq_fail_d = 1'b1;
                    end else begin
                        state_d = BACKOFF;
                        bo_d    = BO_LOAD;
                    end
                end
            end
            BACKOFF: begin
                if (bo_q == '0) begin
                    state_d = ACQ_WR;
                end else begin
                    bo_d = bo_q - 1'b1;
                end
            end
            HELD: begin
                if (rel_req) begin
                    state_d = REL_WR;
                end
            end
            REL_WR: begin
                state_d    = IDLE;
                rel_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes are pure state decodes; writedata is zeroed outside write cycles.
    always_comb begin
        mutex_chipselect = 1'b0;
        mutex_read       = 1'b0;
        mutex_write      = 1'b0;
        mutex_writedata  = '0;
        case (state_q)
            ACQ_WR: begin
                mutex_chipselect = 1'b1;
                mutex_write      = 1'b1;
                mutex_writedata  = ACQ_WORD;
            end
            ACQ_RD: begin
                mutex_chipselect = 1'b1;
                mutex_read       = 1'b1;
            end
            REL_WR: begin
                mutex_chipselect = 1'b1;
                mutex_write      = 1'b1;
                mutex_writedata  = REL_WORD;
            end
            default: ;
        endcase
    end

    // The reset register of the slave is never used by this agent.
    assign mutex_address = 1'b0;
    assign granted       = (state_q == HELD);
    assign busy          = (state_q == ACQ_WR) || (state_q == ACQ_RD) ||
                           (state_q == BACKOFF) || (state_q == REL_WR);
    assign acq_fail      = acq_fail_q;
    assign rel_done      = rel_done_q;
    assign retry_count   = retry_q;

endmodule

// File: tb/tb_mutex_acquire_agent.sv
// Purpose : directed table + sequence bench for mutex_acquire_agent with a behavioural mutex slave.
// Latency : n/a.
// Backpres: n/a.
module tb_mutex_acquire_agent;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // ---------------- DUT A: retry forever, backoff 4 ----------------
    logic        acq_a, rel_a;
    logic        gr_a, fail_a, done_a, busy_a, addr_a, cs_a, rd_a, wr_a;
    logic [7:0]  rc_a;
    logic [31:0] wd_a, rdd_a;

    mutex_acquire_agent #(
        .OWNER_ID(16'h0001), .LOCK_VALUE(16'h0001),
        .BACKOFF_CYCLES(4), .MAX_RETRIES(0), .RETRY_W(8)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .acq_req(acq_a), .rel_req(rel_a),
        .granted(gr_a), .acq_fail(fail_a), .rel_done(done_a), .busy(busy_a),
        .retry_count(rc_a), .mutex_address(addr_a), .mutex_chipselect(cs_a),
        .mutex_read(rd_a), .mutex_write(wr_a), .mutex_writedata(wd_a),
        .mutex_readdata(rdd_a)
    );

    // ---------------- DUT B: two retries max, backoff 3 ----------------
    logic        acq_b, rel_b;
    logic        gr_b, fail_b, done_b, busy_b, addr_b, cs_b, rd_b, wr_b;
    logic [7:0]  rc_b;
    logic [31:0] wd_b, rdd_b;

    mutex_acquire_agent #(
        .OWNER_ID(16'h0001), .LOCK_VALUE(16'h0001),
        .BACKOFF_CYCLES(3), .MAX_RETRIES(2), .RETRY_W(8)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .acq_req(acq_b), .rel_req(rel_b),
        .granted(gr_b), .acq_fail(fail_b), .rel_done(done_b), .busy(busy_b),
        .retry_count(rc_b), .mutex_address(addr_b), .mutex_chipselect(cs_b),
        .mutex_read(rd_b), .mutex_write(wr_b), .mutex_writedata(wd_b),
        .mutex_readdata(rdd_b)
    );

    // ---------------- Behavioural mutex slaves ----------------
    // A write is kept only if the lock is free (value 0) or the owner field matches.
    logic [31:0] mtx_a, mtx_b, pre_dat_a, pre_dat_b;
    logic        pre_a, pre_b;

    assign rdd_a = mtx_a;
    assign rdd_b = mtx_b;

    always @(posedge clk) begin
        if (pre_a) mtx_a <= pre_dat_a;
        else if (cs_a && wr_a && !addr_a && (mtx_a[15:0] == 16'h0 || mtx_a[31:16] == wd_a[31:16]))
            mtx_a <= wd_a;
        if (pre_b) mtx_b <= pre_dat_b;
        else if (cs_b && wr_b && !addr_b && (mtx_b[15:0] == 16'h0 || mtx_b[31:16] == wd_b[31:16]))
            mtx_b <= wd_b;
    end

    // Bus-rule monitor and write counters.
    int viol = 0, wr_cnt_b = 0, rel_wr_a = 0;
    always @(negedge clk) begin
        if (rd_a && wr_a) viol++;
        if (rd_b && wr_b) viol++;
        if (addr_a || addr_b) viol++;
        if (!wr_a && wd_a != 32'h0) viol++;
        if (!wr_b && wd_b != 32'h0) viol++;
        if (cs_b && wr_b) wr_cnt_b++;
        if (cs_a && wr_a && wd_a == 32'h0001_0000) rel_wr_a++;
    end

    // Packed view: {granted, acq_fail, rel_done, busy, address, chipselect, read, write, writedata, retry_count}
    logic [47:0] out_a, out_b;
    assign out_a = {gr_a, fail_a, done_a, busy_a, addr_a, cs_a, rd_a, wr_a, wd_a, rc_a};
    assign out_b = {gr_b, fail_b, done_b, busy_b, addr_b, cs_b, rd_b, wr_b, wd_b, rc_b};

    function automatic logic [47:0] e(input logic g, input logic f, input logic d, input logic b,
                                      input logic c, input logic r, input logic w,
                                      input logic [31:0] wd, input logic [7:0] rc);
        return {g, f, d, b, 1'b0, c, r, w, wd, rc};
    endfunction
    function automatic logic [47:0] ewr(input logic [7:0] rc);  return e(0,0,0,1,1,0,1,32'h0001_0001,rc); endfunction
    function automatic logic [47:0] erd(input logic [7:0] rc);  return e(0,0,0,1,1,1,0,32'h0,rc); endfunction
    function automatic logic [47:0] ebo(input logic [7:0] rc);  return e(0,0,0,1,0,0,0,32'h0,rc); endfunction
    function automatic logic [47:0] ehd(input logic [7:0] rc);  return e(1,0,0,0,0,0,0,32'h0,rc); endfunction
    function automatic logic [47:0] eid(input logic [7:0] rc);  return e(0,0,0,0,0,0,0,32'h0,rc); endfunction
    function automatic logic [47:0] erl(input logic [7:0] rc);  return e(0,0,0,1,1,0,1,32'h0001_0000,rc); endfunction
    function automatic logic [47:0] edn(input logic [7:0] rc);  return e(0,0,1,0,0,0,0,32'h0,rc); endfunction

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        acq;
        logic        rel;
        logic [47:0] exp;
    } vec_t;
    vec_t tbl[12];

    int rel_before;

    initial begin
        // Uncontended acquire, ignored acq in HELD, release, simultaneous requests.
        tbl[0]  = '{1'b1, 1'b0, ewr(0)};
        tbl[1]  = '{1'b0, 1'b0, erd(0)};
        tbl[2]  = '{1'b0, 1'b0, ehd(0)};
        tbl[3]  = '{1'b1, 1'b0, ehd(0)};
        tbl[4]  = '{1'b0, 1'b1, erl(0)};
        tbl[5]  = '{1'b0, 1'b0, edn(0)};
        tbl[6]  = '{1'b0, 1'b0, eid(0)};
        tbl[7]  = '{1'b1, 1'b1, ewr(0)};
        tbl[8]  = '{1'b0, 1'b1, erd(0)};
        tbl[9]  = '{1'b0, 1'b0, ehd(0)};
        tbl[10] = '{1'b0, 1'b1, erl(0)};
        tbl[11] = '{1'b0, 1'b0, edn(0)};

        reset_n = 1'b0; acq_a = 0; rel_a = 0; acq_b = 0; rel_b = 0;
        pre_a = 1'b1; pre_dat_a = 32'h0; pre_b = 1'b1; pre_dat_b = 32'h0;
        step(); step();
        pre_a = 1'b0; pre_b = 1'b0;
        chk("reset_a", out_a, eid(0));
        chk("reset_b", out_b, eid(0));
        reset_n = 1'b1;
        step();
        chk("idle_a", out_a, eid(0));

        for (int i = 0; i < 12; i++) begin
            acq_a = tbl[i].acq; rel_a = tbl[i].rel;
            step();
            chk($sformatf("tbl[%0d]", i), out_a, tbl[i].exp);
        end
        acq_a = 0; rel_a = 0;
        chk32("released_value", {16'h0, mtx_a[15:0]}, 32'h0);

        // Contended: other owner holds, releases during the 3rd backoff.
        pre_a = 1'b1; pre_dat_a = 32'h0002_0005; step(); pre_a = 1'b0;
        acq_a = 1'b1; step(); acq_a = 1'b0;
        chk("cont_wr0", out_a, ewr(0));
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("cont_rd%0d", i), out_a, erd(8'(i - 1)));
            chk32($sformatf("cont_rdata%0d", i), rdd_a, 32'h0002_0005);
            for (int k = 0; k < 4; k++) begin
                if (i == 3 && k == 1) begin pre_a = 1'b1; pre_dat_a = 32'h0; end
                step();
                pre_a = 1'b0;
                chk($sformatf("cont_bo%0d_%0d", i, k), out_a, ebo(8'(i)));
            end
            step();
            chk($sformatf("cont_wr%0d", i), out_a, ewr(8'(i)));
        end
        step(); chk("cont_rd4", out_a, erd(3));
        step(); chk("cont_held", out_a, ehd(3));
        rel_a = 1'b1; step(); rel_a = 1'b0;
        chk("cont_rel", out_a, erl(3));
        step(); chk("cont_done", out_a, edn(3));

        // Exhaustion on dut_b: lock held by owner 3 forever.
        pre_b = 1'b1; pre_dat_b = 32'h0003_0001; step(); pre_b = 1'b0;
        wr_cnt_b = 0;
        acq_b = 1'b1; step(); acq_b = 1'b0;
        chk("exh_wr0", out_b, ewr(0));
        step(); chk("exh_rd0", out_b, erd(0));
        for (int k = 0; k < 3; k++) begin
            step(); chk($sformatf("exh_bo%0d", k), out_b, ebo(1));
        end
        step(); chk("exh_wr1", out_b, ewr(1));
        step(); chk("exh_rd1", out_b, erd(1));
        step(); chk("exh_fail", out_b, e(0,1,0,0,0,0,0,32'h0,2));
        chk32("exh_writes", 32'(wr_cnt_b), 32'd2);
        acq_b = 1'b1; step(); acq_b = 1'b0;
        chk("exh_restart", out_b, ewr(0));

        // Reset during BACKOFF (dut_a contended), also aborts dut_b mid-acquire.
        pre_a = 1'b1; pre_dat_a = 32'h0002_0005; step(); pre_a = 1'b0;
        acq_a = 1'b1; step(); acq_a = 1'b0;
        step(); step();
        rel_a = 1'b1; step(); rel_a = 1'b0;
        chk("bo_ignore_rel", out_a, ebo(1));
        reset_n = 1'b0; step(); reset_n = 1'b1;
        chk("rst_bo_a", out_a, eid(0));
        chk("rst_b", out_b, eid(0));

        pre_a = 1'b1; pre_dat_a = 32'h0; step(); pre_a = 1'b0;
        acq_a = 1'b1; step(); acq_a = 1'b0;
        chk("post_rst_wr", out_a, ewr(0));
        step(); chk("post_rst_rd", out_a, erd(0));
        step(); chk("post_rst_held", out_a, ehd(0));

        // Reset during HELD: lock stays taken, no release write.
        rel_before = rel_wr_a;
        reset_n = 1'b0; step(); reset_n = 1'b1;
        chk("rst_held_a", out_a, eid(0));
        step();
        chk32("rst_no_relwr", 32'(rel_wr_a), 32'(rel_before));
        chk32("rst_lock_kept", mtx_a, 32'h0001_0001);
        acq_a = 1'b1; step(); acq_a = 1'b0;
        chk("reacq_wr", out_a, ewr(0));
        step(); chk("reacq_rd", out_a, erd(0));
        step(); chk("reacq_held", out_a, ehd(0));

        chk32("bus_rules", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
